// File: rtl/grad_gen_pkg.sv
// Shared definitions for the gradient-generator pump sequencer: FSM states,
// default sizing and the run-configuration sanity check.
package grad_gen_pkg;

  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 1000;
  localparam int unsigned PULSE_CYCLES_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAKE     = 2'd1,
    DISPENSE = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  // A run is unusable if nothing is to be dispensed, or if a step pulse
  // would not have returned low before the next major tick.
  function automatic logic cfg_reject(input logic [31:0] va, input logic [31:0] vb,
                                      input logic [31:0] per, input logic [31:0] pulse);
    return ((va == '0) && (vb == '0)) || (per <= pulse);
  endfunction

endpackage

// File: rtl/grad_gen_ratio_acc.sv
// Bresenham ratio accumulator: spreads `minor` fires evenly across `major`
// ticks so the minor channel finishes on the last major tick.
module grad_gen_ratio_acc
  import grad_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] major,
  input  logic [CNT_W-1:0] minor,
  output logic             minor_fire
);

  logic [CNT_W:0] acc;
  logic [CNT_W:0] sum;

  // acc stays below major, so one extra bit holds acc + minor without overflow.
  always_comb begin
    sum        = acc + {1'b0, minor};
    minor_fire = tick && (sum >= {1'b0, major});
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (tick) begin
      acc <= minor_fire ? (sum - {1'b0, major}) : sum;
    end
  end

endmodule

// File: rtl/grad_gen_pump_seq.sv
// Two-channel ratio-locked syringe-pump sequencer: wake drivers, dispense
// interleaved step pulses, let pressure settle, then report done.
module grad_gen_pump_seq
  import grad_gen_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES  = PULSE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] vol_a,
  input  logic [CNT_W-1:0] vol_b,
  input  logic [CNT_W-1:0] period,
  output logic             step_a,
  output logic             step_b,
  output logic             en_a,
  output logic             en_b,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PMAX  = PW'(PULSE_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] va_r, vb_r, per_r;
  logic [CNT_W-1:0] pcnt, tcnt;
  logic [SW-1:0]    wcnt;
  logic [PW-1:0]    pca, pcb;

  logic             maj_a, wake_last, per_last, tick, minor_fire, accept;
  logic             fire_a, fire_b;
  logic [CNT_W-1:0] maj_cnt, min_cnt;

  always_comb begin
    maj_a     = (va_r >= vb_r);
    maj_cnt   = maj_a ? va_r : vb_r;
    min_cnt   = maj_a ? vb_r : va_r;
    wake_last = (wcnt == SLAST);
    per_last  = (pcnt == per_r - 1'b1);
    // A tick is registered on the edge before its cycle so the step output
    // is already high during the tick cycle itself.
    tick      = !abort && (((state == WAKE) && wake_last) ||
                           ((state == DISPENSE) && per_last && (tcnt != maj_cnt)));
    accept    = (state == IDLE) && start && !abort &&
                !cfg_reject(32'(vol_a), 32'(vol_b), 32'(period), 32'(PULSE_CYCLES));
    fire_a    = maj_a ? tick : minor_fire;
    fire_b    = maj_a ? minor_fire : tick;
  end

  grad_gen_ratio_acc #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .tick       (tick),
    .major      (maj_cnt),
    .minor      (min_cnt),
    .minor_fire (minor_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      va_r   <= '0;
      vb_r   <= '0;
      per_r  <= '0;
      pcnt   <= '0;
      tcnt   <= '0;
      wcnt   <= '0;
      pca    <= '0;
      pcb    <= '0;
      step_a <= 1'b0;
      step_b <= 1'b0;
      en_a   <= 1'b0;
      en_b   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state != IDLE) && abort) begin
        state  <= IDLE;
        step_a <= 1'b0;
        step_b <= 1'b0;
        en_a   <= 1'b0;
        en_b   <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              va_r  <= vol_a;
              vb_r  <= vol_b;
              per_r <= period;
              if (accept) begin
                err   <= 1'b0;
                busy  <= 1'b1;
                en_a  <= (vol_a != '0);
                en_b  <= (vol_b != '0);
                wcnt  <= '0;
                state <= WAKE;
              end else begin
                err  <= 1'b1;
                done <= 1'b1;
              end
            end
          end
          WAKE: begin
            if (wake_last) begin
              state <= DISPENSE;
              pcnt  <= '0;
              tcnt  <= CNT_W'(1);
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          DISPENSE: begin
            if (per_last) begin
              pcnt <= '0;
              if (tcnt == maj_cnt) begin
                state <= SETTLE;
                wcnt  <= '0;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          SETTLE: begin
            if (wake_last) begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
              en_a  <= 1'b0;
              en_b  <= 1'b0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (fire_a) begin
          step_a <= 1'b1;
          pca    <= PW'(1);
        end else if (step_a) begin
          if (pca == PMAX) step_a <= 1'b0;
          else             pca    <= pca + 1'b1;
        end

        if (fire_b) begin
          step_b <= 1'b1;
          pcb    <= PW'(1);
        end else if (step_b) begin
          if (pcb == PMAX) step_b <= 1'b0;
          else             pcb    <= pcb + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grad_gen_pump_seq.sv
// Scoreboard bench for grad_gen_pump_seq: every output transition is an
// expected event (signal, value, cycle) queued by the stimulus.
module tb_grad_gen_pump_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] vol_a, vol_b, period;
  logic        step_a, step_b, en_a, en_b, busy, done, err;

  always #5 clk = ~clk;

  grad_gen_pump_seq #(
    .CNT_W         (16),
    .SETTLE_CYCLES (4),
    .PULSE_CYCLES  (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .vol_a  (vol_a),
    .vol_b  (vol_b),
    .period (period),
    .step_a (step_a),
    .step_b (step_b),
    .en_a   (en_a),
    .en_b   (en_b),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  localparam int SA = 0, SB = 1, EA = 2, EB = 3, BY = 4, DN = 5, ER = 6;
  string nm [7] = '{"step_a", "step_b", "en_a", "en_b", "busy", "done", "err"};

  typedef struct {
    int   sig;
    logic val;
    int   cyc;
  } ev_t;

  ev_t  q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic mon_on = 1'b0;
  logic [6:0] prev = '0;
  logic [6:0] cur;

  assign cur = {err, done, busy, en_b, en_a, step_b, step_a};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int s, input logic v, input int c);
    ev_t e;
    e.sig = s;
    e.val = v;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic pulse(input int s, input int c);
    ex(s, 1'b1, c);
    ex(s, 1'b0, c + 2);
  endtask

  task automatic check_evt(input int s, input logic v, input int c);
    int idx = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].sig == s) begin
        idx = i;
        break;
      end
    end
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL evt_%s: unexpected change to %0b at cycle %0d", nm[s], v, c);
    end else begin
      if (q[idx].val !== v || q[idx].cyc != c) begin
        n_bad++;
        $display("FAIL evt_%s: got %0b at cycle %0d, want %0b at cycle %0d",
                 nm[s], v, c, q[idx].val, q[idx].cyc);
      end
      q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int s = 0; s < 7; s++) begin
        if (cur[s] !== prev[s]) check_evt(s, cur[s], cyc + 1);
      end
      prev = cur;
    end
  end

  task automatic chk(input string name, input logic act, input logic want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", name, act, want);
    end
  endtask

  // Called on a negedge; returns on the negedge just before edge e.
  task automatic at_edge(input int e);
    while (cyc + 1 < e) @(negedge clk);
  endtask

  task automatic go(input logic [15:0] va, input logic [15:0] vb,
                    input logic [15:0] pr, output int t);
    vol_a  = va;
    vol_b  = vb;
    period = pr;
    start  = 1'b1;
    t      = cyc + 1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic push_s1(input int t);
    ex(EA, 1'b1, t + 1); ex(EA, 1'b0, t + 29);
    ex(EB, 1'b1, t + 1); ex(EB, 1'b0, t + 29);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 29);
    pulse(SA, t + 5); pulse(SA, t + 10); pulse(SA, t + 15); pulse(SA, t + 20);
    pulse(SB, t + 10); pulse(SB, t + 20);
    ex(DN, 1'b1, t + 29); ex(DN, 1'b0, t + 30);
  endtask

  initial begin
    int t, t2;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    vol_a = '0; vol_b = '0; period = '0;
    repeat (3) @(negedge clk);
    chk("rst_step_a", step_a, 1'b0);
    chk("rst_step_b", step_b, 1'b0);
    chk("rst_en_a", en_a, 1'b0);
    chk("rst_en_b", en_b, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    // 1: A major 4:2
    go(16'd4, 16'd2, 16'd5, t); push_s1(t); idle_in(); at_edge(t + 32);

    // 2: B only
    go(16'd0, 16'd3, 16'd3, t);
    ex(EB, 1'b1, t + 1); ex(EB, 1'b0, t + 18);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 18);
    pulse(SB, t + 5); pulse(SB, t + 8); pulse(SB, t + 11);
    ex(DN, 1'b1, t + 18); ex(DN, 1'b0, t + 19);
    idle_in(); at_edge(t + 21);

    // 3: equal volumes, coincident steps
    go(16'd3, 16'd3, 16'd4, t);
    ex(EA, 1'b1, t + 1); ex(EA, 1'b0, t + 21);
    ex(EB, 1'b1, t + 1); ex(EB, 1'b0, t + 21);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 21);
    pulse(SA, t + 5); pulse(SA, t + 9); pulse(SA, t + 13);
    pulse(SB, t + 5); pulse(SB, t + 9); pulse(SB, t + 13);
    ex(DN, 1'b1, t + 21); ex(DN, 1'b0, t + 22);
    idle_in(); at_edge(t + 24);

    // 4: rejected configs, then a minimal valid run clears err
    go(16'd0, 16'd0, 16'd5, t);
    ex(ER, 1'b1, t + 1); ex(DN, 1'b1, t + 1); ex(DN, 1'b0, t + 2);
    idle_in(); at_edge(t + 4);
    chk("zero_vol_busy", busy, 1'b0);
    go(16'd1, 16'd0, 16'd2, t);
    ex(DN, 1'b1, t + 1); ex(DN, 1'b0, t + 2);
    idle_in(); at_edge(t + 4);
    chk("short_period_err", err, 1'b1);
    chk("short_period_busy", busy, 1'b0);
    go(16'd1, 16'd0, 16'd3, t);
    ex(ER, 1'b0, t + 1);
    ex(EA, 1'b1, t + 1); ex(EA, 1'b0, t + 12);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 12);
    pulse(SA, t + 5);
    ex(DN, 1'b1, t + 12); ex(DN, 1'b0, t + 13);
    idle_in(); at_edge(t + 15);

    // 5: abort mid-run, then a fresh run
    go(16'd4, 16'd2, 16'd5, t);
    ex(EA, 1'b1, t + 1); ex(EA, 1'b0, t + 13);
    ex(EB, 1'b1, t + 1); ex(EB, 1'b0, t + 13);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 13);
    pulse(SA, t + 5); pulse(SA, t + 10); pulse(SB, t + 10);
    idle_in(); at_edge(t + 12); abort = 1'b1;
    idle_in(); at_edge(t + 15);
    go(16'd4, 16'd2, 16'd5, t2);
    push_s1(t2); idle_in(); at_edge(t2 + 32);

    // 5b: abort truncates a pulse in its first cycle
    go(16'd4, 16'd2, 16'd5, t);
    ex(EA, 1'b1, t + 1); ex(EA, 1'b0, t + 6);
    ex(EB, 1'b1, t + 1); ex(EB, 1'b0, t + 6);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 6);
    ex(SA, 1'b1, t + 5); ex(SA, 1'b0, t + 6);
    idle_in(); at_edge(t + 5); abort = 1'b1;
    idle_in(); at_edge(t + 9);

    // start together with abort in IDLE is dropped
    go(16'd4, 16'd2, 16'd5, t); abort = 1'b1;
    idle_in(); at_edge(t + 8);
    chk("abort_start_busy", busy, 1'b0);

    // 6: start during run ignored, then rst mid-run with start held
    go(16'd4, 16'd2, 16'd5, t);
    ex(EA, 1'b1, t + 1); ex(EA, 1'b0, t + 13);
    ex(EB, 1'b1, t + 1); ex(EB, 1'b0, t + 13);
    ex(BY, 1'b1, t + 1); ex(BY, 1'b0, t + 13);
    pulse(SA, t + 5); pulse(SA, t + 10); pulse(SB, t + 10);
    idle_in(); at_edge(t + 8);
    go(16'd1, 16'd1, 16'd9, t2);
    idle_in(); at_edge(t + 12); rst = 1'b1;
    @(negedge clk);
    go(16'd4, 16'd2, 16'd5, t2);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_run_busy", busy, 1'b0);
    chk("rst_run_err", err, 1'b0);
    at_edge(t + 22);

    // rst clears a sticky err
    go(16'd0, 16'd0, 16'd5, t);
    ex(ER, 1'b1, t + 1); ex(DN, 1'b1, t + 1); ex(DN, 1'b0, t + 2);
    idle_in(); at_edge(t + 4); rst = 1'b1;
    ex(ER, 1'b0, t + 5);
    @(negedge clk); rst = 1'b0;
    at_edge(t + 8);
    chk("rst_clears_err", err, 1'b0);

    mon_on = 1'b0;
    foreach (q[i]) begin
      n_vec++;
      n_bad++;
      $display("FAIL evt_%s: missing change to %0b at cycle %0d", nm[q[i].sig], q[i].val, q[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
